// File: rtl/mm_pkg.sv
// Shared constants and types for the matrix-multiplier result path.
package mm_pkg;
    localparam int MM_ADDR_WIDTH   = 7;
    localparam int MM_RESULT_WIDTH = 24;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        CHECK,
        DONE
    } streamer_state_t;
endpackage

// File: rtl/result_fifo.sv
// Two-entry synchronous FIFO that absorbs the one-cycle RAM read latency.
module result_fifo
    import mm_pkg::*;
#(
    parameter int WIDTH = MM_RESULT_WIDTH
) (
    input  logic             gclk,
    input  logic             grst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);
    logic [1:0][WIDTH-1:0] mem;
    logic                  wr_ptr;
    logic                  rd_ptr;

    always_ff @(posedge gclk) begin
        if (!grst_n) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    // Stale entries stay hidden so the stream data reads zero when empty.
    assign head = (count != 2'd0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/result_streamer.sv
// Drains the result RAM onto a valid/ready stream after end_operation.
// Optional checksum compare: define RESULT_STREAMER_CHECKSUM_EN.
module result_streamer
    import mm_pkg::*;
#(
    parameter int ADDR_WIDTH   = MM_ADDR_WIDTH,
    parameter int RESULT_WIDTH = MM_RESULT_WIDTH,
    parameter int NUM_WORDS    = 128
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    start,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_en,
    input  logic [RESULT_WIDTH-1:0] rd_data,
    input  logic [RESULT_WIDTH-1:0] expected_sum,
    output logic [RESULT_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic                    sum_ok
);
    // One extra bit so a full 2**ADDR_WIDTH run is countable.
    localparam int CW = ADDR_WIDTH + 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t N_WORDS  = cnt_t'(NUM_WORDS);
    localparam cnt_t LAST_IDX = cnt_t'(NUM_WORDS - 1);

    streamer_state_t state_q, state_d;
    cnt_t            rd_cnt;
    cnt_t            beat_cnt;
    logic            inflight;
    logic            pop;
    logic            start_run;
    logic            last_accept;
    logic [1:0]      fifo_count;
    logic [2:0]      occ;

    result_fifo #(.WIDTH(RESULT_WIDTH)) u_fifo (
        .gclk      (CLOCK_50),
        .grst_n    (reset),
        .push      (inflight),
        .push_data (rd_data),
        .pop       (pop),
        .head      (out_data),
        .count     (fifo_count)
    );

    assign pop         = out_valid && out_ready;
    assign occ         = {1'b0, fifo_count} + {2'b00, inflight};
    assign rd_en       = (state_q == STREAM) && (rd_cnt < N_WORDS)
                         && (occ < (3'd2 + {2'b00, pop}));
    assign rd_addr     = rd_cnt[ADDR_WIDTH-1:0];
    assign out_valid   = (fifo_count != 2'd0);
    assign out_last    = out_valid && (beat_cnt == LAST_IDX);
    assign last_accept = pop && out_last;
    assign start_run   = (state_q == IDLE) && start;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start) state_d = STREAM;
`ifdef RESULT_STREAMER_CHECKSUM_EN
            STREAM: if (last_accept) state_d = CHECK;
`else
            STREAM: if (last_accept) state_d = DONE;
`endif
            CHECK:  state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q  <= IDLE;
            rd_cnt   <= '0;
            beat_cnt <= '0;
            inflight <= 1'b0;
        end else begin
            state_q  <= state_d;
            inflight <= rd_en;
            if (start_run) begin
                rd_cnt   <= '0;
                beat_cnt <= '0;
            end else begin
                if (rd_en) rd_cnt <= rd_cnt + cnt_t'(1);
                if (pop)   beat_cnt <= beat_cnt + cnt_t'(1);
            end
        end
    end

`ifdef RESULT_STREAMER_CHECKSUM_EN
    logic [RESULT_WIDTH-1:0] acc;
    logic                    sum_ok_q;

    // Accumulator wraps modulo 2**RESULT_WIDTH, matching ResultMatrixSum.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            acc      <= '0;
            sum_ok_q <= 1'b0;
        end else begin
            if (start_run) begin
                acc      <= '0;
                sum_ok_q <= 1'b0;
            end else if (pop) begin
                acc <= acc + out_data;
            end
            if (state_q == CHECK) sum_ok_q <= (acc == expected_sum);
        end
    end

    assign sum_ok = sum_ok_q;
`else
    logic unused_expected_sum;
    assign unused_expected_sum = ^expected_sum;
    assign sum_ok = 1'b0;
`endif
endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: a 4-word instance and a 128-word instance.
module tb_result_streamer;
`ifdef RESULT_STREAMER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    // Instance A: NUM_WORDS = 4
    logic        start_a, rd_en_a, out_valid_a, out_ready_a, out_last_a, busy_a, done_a, sum_ok_a;
    logic [6:0]  rd_addr_a;
    logic [23:0] rd_data_a, exp_a, out_data_a;
    logic [23:0] ram_a [4];

    // Instance B: NUM_WORDS = 128
    logic        start_b, rd_en_b, out_valid_b, out_ready_b, out_last_b, busy_b, done_b, sum_ok_b;
    logic [6:0]  rd_addr_b;
    logic [23:0] rd_data_b, exp_b, out_data_b;
    logic [23:0] ram_b [128];

    result_streamer #(.ADDR_WIDTH(7), .RESULT_WIDTH(24), .NUM_WORDS(4)) dut_a (
        .CLOCK_50(clk), .reset(rst_n), .start(start_a), .rd_addr(rd_addr_a), .rd_en(rd_en_a),
        .rd_data(rd_data_a), .expected_sum(exp_a), .out_data(out_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_last(out_last_a), .busy(busy_a), .done(done_a), .sum_ok(sum_ok_a)
    );

    result_streamer #(.ADDR_WIDTH(7), .RESULT_WIDTH(24), .NUM_WORDS(128)) dut_b (
        .CLOCK_50(clk), .reset(rst_n), .start(start_b), .rd_addr(rd_addr_b), .rd_en(rd_en_b),
        .rd_data(rd_data_b), .expected_sum(exp_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_last(out_last_b), .busy(busy_b), .done(done_b), .sum_ok(sum_ok_b)
    );

    // RAM models: one-cycle read latency
    always @(posedge clk) if (rd_en_a) rd_data_a <= ram_a[rd_addr_a[1:0]];
    always @(posedge clk) if (rd_en_b) rd_data_b <= ram_b[rd_addr_b];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Single run on instance A with out_ready held high; cycle 0 is the start cycle.
    task automatic run_a(input string tag, input logic [23:0] esum, input bit exp_ok, input bit repulse);
        logic [23:0] bv [4];
        int          bc [4];
        logic        bl [4];
        int beats = 0, done_cnt = 0, done_cyc = -1, first_rd = -1, first_vld = -1;
        logic busy1 = 1'b0, sok = 1'b0;
        for (int i = 0; i < 4; i++) begin bv[i] = '0; bc[i] = -1; bl[i] = 1'b0; end
        exp_a = esum;
        out_ready_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            if (cyc == 1) busy1 = busy_a;
            if (rd_en_a && first_rd < 0) first_rd = cyc;
            if (out_valid_a && first_vld < 0) first_vld = cyc;
            if (out_valid_a && out_ready_a) begin
                if (beats < 4) begin bv[beats] = out_data_a; bc[beats] = cyc; bl[beats] = out_last_a; end
                beats++;
            end
            if (done_a) begin done_cnt++; done_cyc = cyc; sok = sum_ok_a; end
            @(posedge clk); #1;
            start_a = repulse && (cyc == 2);
        end
        chk({tag, "_busy_c1"}, busy1, 1);
        chk({tag, "_first_rd"}, first_rd, 1);
        chk({tag, "_first_vld"}, first_vld, 3);
        chk({tag, "_beats"}, beats, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_data%0d", tag, i), bv[i], ram_a[i]);
            chk($sformatf("%s_cyc%0d", tag, i), bc[i], 3 + i);
            chk($sformatf("%s_last%0d", tag, i), bl[i], i == 3);
        end
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_done_cyc"}, done_cyc, CK ? 8 : 7);
        chk({tag, "_sum_ok"}, sok, CK && exp_ok);
        chk({tag, "_sum_ok_held"}, sum_ok_a, CK && exp_ok);
        chk({tag, "_idle"}, busy_a, 0);
    endtask

    initial begin
        logic [23:0] sum_b;
        int   cyc, beats, issued, done_cnt, order_err, ovf_err, stab_err, last_err, addr_err;
        logic prev_stall, prev_last;
        logic [23:0] prev_data;

        rst_n = 1'b0;
        start_a = 1'b0; out_ready_a = 1'b1; exp_a = '0; rd_data_a = '0;
        start_b = 1'b0; out_ready_b = 1'b0; exp_b = '0; rd_data_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_outs", {rd_addr_a, rd_en_a, out_data_a, out_valid_a, out_last_a, busy_a, done_a, sum_ok_a}, 0);
        chk("rst_b_outs", {rd_addr_b, rd_en_b, out_data_b, out_valid_b, out_last_b, busy_b, done_b, sum_ok_b}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        ram_a[0] = 24'd10; ram_a[1] = 24'd20; ram_a[2] = 24'd30; ram_a[3] = 24'd40;
        run_a("basic", 24'd100, 1'b1, 1'b0);
        run_a("badsum", 24'd99, 1'b0, 1'b0);

        ram_a[0] = 24'hFFFFFF; ram_a[1] = 24'h000002; ram_a[2] = 24'd0; ram_a[3] = 24'd0;
        run_a("wrap", 24'h000001, 1'b1, 1'b0);

        // Reset asserted in cycle 5 of a run
        ram_a[0] = 24'd10; ram_a[1] = 24'd20; ram_a[2] = 24'd30; ram_a[3] = 24'd40;
        out_ready_a = 1'b0;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_outs", {rd_addr_a, rd_en_a, out_data_a, out_valid_a, out_last_a, busy_a, done_a, sum_ok_a}, 0);
        run_a("post_rst", 24'd100, 1'b1, 1'b0);
        run_a("repulse", 24'd100, 1'b1, 1'b1);

        // 128-word run with ~30% ready
        sum_b = '0;
        for (int i = 0; i < 128; i++) begin
            ram_b[i] = (24'(i) * 24'h010203) ^ 24'h5A5A5A;
            sum_b += ram_b[i];
        end
        exp_b = sum_b;
        cyc = 0; beats = 0; issued = 0; done_cnt = 0;
        order_err = 0; ovf_err = 0; stab_err = 0; last_err = 0; addr_err = 0;
        prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        out_ready_b = ($urandom_range(0, 99) < 30);
        while (done_cnt == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall && (out_data_b !== prev_data || out_last_b !== prev_last)) stab_err++;
            if (rd_en_b) begin
                if (int'(rd_addr_b) != issued) addr_err++;
                if ((issued - beats) - int'(out_valid_b && out_ready_b) >= 2) ovf_err++;
                issued++;
            end
            if (out_valid_b && out_ready_b) begin
                if (beats > 127 || out_data_b !== ram_b[beats[6:0]]) order_err++;
                if (out_last_b !== (beats == 127)) last_err++;
                beats++;
            end
            prev_stall = out_valid_b && !out_ready_b;
            prev_data  = out_data_b;
            prev_last  = out_last_b;
            if (done_b) done_cnt++;
            @(posedge clk); #1;
            out_ready_b = ($urandom_range(0, 99) < 30);
        end
        chk("b_timeout", done_cnt, 1);
        chk("b_beats", beats, 128);
        chk("b_reads", issued, 128);
        chk("b_order_errs", order_err, 0);
        chk("b_overflow_errs", ovf_err, 0);
        chk("b_stall_errs", stab_err, 0);
        chk("b_last_errs", last_err, 0);
        chk("b_addr_errs", addr_err, 0);
        chk("b_sum_ok", sum_ok_b, CK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
